// File: rtl/id_inst_queue.sv
// id_inst_queue: DEPTH-entry first-word-fall-through buffer between IF and ID.
// IF pushes {pc, inst} words, ID pops them in order. A one-cycle flush is
// raised by cancle. The input-side allowin depends on registered state only.
module id_inst_queue #(
    parameter int DATA_WD = 64,
    parameter int DEPTH   = 4,
    parameter int PTR_WD  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cancle,
    input  logic               in_valid,
    input  logic [DATA_WD-1:0] in_data,
    output logic               in_allowin,
    output logic               out_valid,
    output logic [DATA_WD-1:0] out_data,
    input  logic               out_ready,
    output logic [PTR_WD:0]    count
);

    localparam logic [PTR_WD:0] L_FULL = (PTR_WD+1)'(DEPTH);

    logic [DEPTH-1:0][DATA_WD-1:0] r_mem;
    logic [PTR_WD-1:0]             r_rd_ptr;
    logic [PTR_WD-1:0]             r_wr_ptr;
    logic [PTR_WD:0]               r_count;

    logic w_push;
    logic w_pop;

    // Handshake decode; cancle masks both sides so a flush wins over traffic
    always_comb begin
        in_allowin = (r_count != L_FULL);
        out_valid  = (r_count != '0) && !cancle;
        out_data   = r_mem[r_rd_ptr];
        w_push     = in_valid && in_allowin && !cancle;
        w_pop      = out_valid && out_ready;
        count      = r_count;
    end

    // Storage write; contents survive a flush and are only zeroed by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap through natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (cancle) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_WD'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_WD+1)'(1);
                2'b01:   r_count <= r_count - (PTR_WD+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Scoreboard bench for id_inst_queue: three instances (DEPTH 4/64b, 2/64b,
// 16/96b). Stimulus pushes expected words into per-instance queues; a negedge
// monitor compares occupancy, handshake and head data against the model.
module tb_id_inst_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic [95:0] din  [3];
    logic        ordy [3];
    logic        canc [3];
    logic        alw  [3];
    logic        ov   [3];
    logic [95:0] dout [3];
    logic [4:0]  cnt  [3];

    logic [63:0] d0, d1;
    logic [95:0] d2;
    logic [2:0]  c0;
    logic [1:0]  c1;
    logic [4:0]  c2;

    id_inst_queue #(.DATA_WD(64), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .cancle(canc[0]), .in_valid(iv[0]), .in_data(din[0][63:0]),
        .in_allowin(alw[0]), .out_valid(ov[0]), .out_data(d0), .out_ready(ordy[0]), .count(c0));
    id_inst_queue #(.DATA_WD(64), .DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .cancle(canc[1]), .in_valid(iv[1]), .in_data(din[1][63:0]),
        .in_allowin(alw[1]), .out_valid(ov[1]), .out_data(d1), .out_ready(ordy[1]), .count(c1));
    id_inst_queue #(.DATA_WD(96), .DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .cancle(canc[2]), .in_valid(iv[2]), .in_data(din[2]),
        .in_allowin(alw[2]), .out_valid(ov[2]), .out_data(d2), .out_ready(ordy[2]), .count(c2));

    assign dout[0] = {32'h0, d0};
    assign dout[1] = {32'h0, d1};
    assign dout[2] = d2;
    assign cnt[0]  = {2'b0, c0};
    assign cnt[1]  = {3'b0, c1};
    assign cnt[2]  = c2;

    int total = 0;
    int bad   = 0;
    int mcnt [3];
    int dep  [3] = '{4, 2, 16};

    logic [95:0] q0[$];
    logic [95:0] q1[$];
    logic [95:0] q2[$];

    task automatic chk(input string n, input int k, input logic [95:0] a, input logic [95:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h", n, k, $time, a, e);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [95:0] qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qpush(input int k, input logic [95:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qclear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    // Word layout per instance: 64-bit {pc, inst}, 96-bit adds a tag on top
    function automatic logic [95:0] mk(input int k, input logic [31:0] pc, input logic [31:0] inst);
        if (k == 2) return {32'hC0DE0000 | pc, pc, inst};
        return {32'h0, pc, inst};
    endfunction

    // One clock of stimulus on instance k; model next-state applied at the edge
    task automatic cyc(input int k, input bit v, input logic [95:0] d, input bit r, input bit c);
        bit push, pop;
        int nxt;
        iv[k] = v; din[k] = d; ordy[k] = r; canc[k] = c;
        push = v && (mcnt[k] != dep[k]) && !c;
        pop  = (mcnt[k] != 0) && r && !c;
        if (c) begin
            qclear(k);
            nxt = 0;
        end else begin
            if (push) qpush(k, d);
            nxt = mcnt[k] + int'(push) - int'(pop);
        end
        @(posedge clk);
        mcnt[k] = nxt;
        #1;
        iv[k] = 1'b0; ordy[k] = 1'b0; canc[k] = 1'b0; din[k] = '0;
    endtask

    // Monitor: handshake/occupancy every cycle, head data whenever presented
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                chk("count", k, 96'(cnt[k]), 96'(mcnt[k]));
                chk("out_valid", k, 96'(ov[k]), 96'((mcnt[k] != 0) && !canc[k]));
                chk("in_allowin", k, 96'(alw[k]), 96'(mcnt[k] != dep[k]));
                if (ov[k]) begin
                    if (qsize(k) == 0) begin
                        chk("unexpected_word", k, dout[k], 96'h0);
                        if (dout[k] === 96'h0) begin
                            bad++;
                            $display("FAIL unexpected_word[u%0d]: got out_valid=1 expected no word", k);
                        end
                    end else begin
                        chk("out_data", k, dout[k], qfront(k));
                        if (ordy[k]) qpop(k);
                    end
                end
            end
        end
    end

    // Fill to full, offer extra words, drain, then cancel with traffic
    task automatic scen_fdc(input int k);
        for (int i = 0; i < dep[k]; i++)
            cyc(k, 1, mk(k, 32'h1000 + 32'(4*i), 32'h13 + 32'(32'h80*i)), 0, 0);
        cyc(k, 1, mk(k, 32'hDEAD0000, 32'h6F), 0, 0);
        cyc(k, 1, mk(k, 32'hDEAD0004, 32'h6F), 0, 0);
        for (int i = 0; i < dep[k]; i++) cyc(k, 0, '0, 1, 0);
        cyc(k, 0, '0, 1, 0);
        cyc(k, 1, mk(k, 32'h1100, 32'h13), 0, 0);
        cyc(k, 1, mk(k, 32'h1104, 32'h93), 0, 0);
        cyc(k, 1, mk(k, 32'hBAD0, 32'h73), 1, 1);
        cyc(k, 0, '0, 0, 0);
        cyc(k, 1, mk(k, 32'h3000, 32'h13), 0, 0);
        cyc(k, 0, '0, 1, 0);
        cyc(k, 0, '0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 0; din[k] = '0; ordy[k] = 0; canc[k] = 0; mcnt[k] = 0;
        end
        #1;
        chk("rst_count", 0, 96'(cnt[0]), 96'h0);
        chk("rst_out_valid", 0, 96'(ov[0]), 96'h0);
        chk("rst_in_allowin", 0, 96'(alw[0]), 96'h1);
        chk("rst_out_data", 0, dout[0], 96'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) scen_fdc(k);

        // Streaming with one preloaded entry: 12 push+pop cycles wrap DEPTH=4 thrice
        cyc(0, 1, mk(0, 32'h2000, 32'h13), 0, 0);
        for (int i = 1; i <= 12; i++) cyc(0, 1, mk(0, 32'h2000 + 32'(4*i), 32'h13), 1, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0);

        // cancle held several cycles with traffic keeps the queue empty
        cyc(0, 1, mk(0, 32'h4000, 32'h13), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, mk(0, 32'h4100 + 32'(4*i), 32'h13), 1, 1);
        cyc(0, 1, mk(0, 32'h4200, 32'h93), 0, 0);
        cyc(0, 0, '0, 1, 0);

        // Asynchronous reset between edges with 3 entries held
        for (int i = 0; i < 3; i++) cyc(0, 1, mk(0, 32'h5000 + 32'(4*i), 32'h13), 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 0, 96'(cnt[0]), 96'h0);
        chk("async_rst_out_valid", 0, 96'(ov[0]), 96'h0);
        chk("async_rst_in_allowin", 0, 96'(alw[0]), 96'h1);
        chk("async_rst_out_data", 0, dout[0], 96'h0);
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            qclear(k);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 1, mk(0, 32'h6000, 32'h33), 0, 0);
        cyc(0, 1, mk(0, 32'h6004, 32'hB3), 1, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 0);

        for (int k = 0; k < 3; k++) chk("sb_empty", k, 96'(qsize(k)), 96'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_inst_queue.md
# id_inst_queue

Parametrised instruction buffer between the IF and ID stages. It replaces the single-entry IF→ID data latch with a DEPTH-entry FIFO. It keeps the valid/allowin handshake of the pipeline, adds an occupancy count, and adds a single-cycle flush driven by `cancle`. IF pushes `{pc, inst}` words, and ID pops them in program order.

## Interface
- `DATA_WD`, default 64: width of one entry, which is `{pc[31:0], inst[31:0]}` in the standard build.
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `PTR_WD`, default $clog2(DEPTH): pointer width. Derived; never overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cancle`  in  1  flush request from a branch mispredict or jump redirect.
- `in_valid`  in  1  IF has a word on `in_data`.
- `in_data`  in  DATA_WD  word offered by IF.
- `in_allowin`  out  1  queue can accept a word this cycle.
- `out_valid`  out  1  head entry is valid for ID.
- `out_data`  out  DATA_WD  head entry.
- `out_ready`  in  1  ID consumes the head this cycle (ID computes this as `id_ready_go && exe_allowin`).
- `count`  out  PTR_WD+1  current occupancy, 0..DEPTH.

## Operation
- Storage is DEPTH x DATA_WD registers, with `rd_ptr` and `wr_ptr` (PTR_WD bits each) and `count`.
- `in_allowin = (count != DEPTH)`. It is a registered-state function only, with no combinational path from `out_ready`.
- `out_valid = (count != 0) && !cancle`.
- `out_data = mem[rd_ptr]`, first-word-fall-through, read directly from storage.
- `push = in_valid && in_allowin && !cancle`. On push: `mem[wr_ptr] <= in_data` and `wr_ptr <= wr_ptr + 1`.
- `pop = out_valid && out_ready`. On pop: `rd_ptr <= rd_ptr + 1`.
- Pointers wrap modulo DEPTH through natural PTR_WD overflow.
- Count update:
  - `+1` on push only.
  - `-1` on pop only.
  - unchanged on push and pop together.
- Flush: when `cancle` is high, `rd_ptr`, `wr_ptr` and `count` are cleared on the next edge.
  - Any word offered that cycle is discarded even though `in_allowin` may be high. IF is cancelled in the same cycle, so nothing is lost.
  - Storage contents are not cleared.
  - `cancle` has priority over push and pop.
- The queue has no bypass path. A word pushed into an empty queue appears on `out_valid` and `out_data` in the following cycle.
- Illegal usage:
  - Pushing while `in_allowin` is low is ignored (no push).
  - `out_ready` while `out_valid` is low is ignored (no pop).

## Timing
- Reset (asynchronous, applied immediately): `rd_ptr = wr_ptr = 0`, `count = 0`, all storage = 0. Resulting outputs:
  - `out_valid = 0`
  - `out_data = 0`
  - `in_allowin = 1`
  - `count = 0`
- Latency from push to visible at the head is 1 cycle.
- Throughput is 1 push and 1 pop per cycle while `0 < count < DEPTH`.
- Full (`count == DEPTH`):
  - `in_allowin = 0`.
  - A pop in that cycle makes `in_allowin = 1` in the next cycle.
  - There is no same-cycle refill.
- Empty (`count == 0`): `out_valid = 0`, and a push in that cycle gives `out_valid = 1` next cycle.
- Cancel cycle: `out_valid` is forced to 0 combinationally. The next cycle shows `count = 0`, `out_valid = 0` and `in_allowin = 1`.
- `cancle` held for several cycles keeps the queue empty throughout.
- A push in the first cycle after `cancle` drops is accepted normally.
- Reset asserted mid-operation clears all state asynchronously, regardless of clock phase. The first push after release lands at entry 0.

## Test plan
- **Reset:** assert `rst` between edges with the queue holding 3 entries -> immediately `count = 0`, `out_valid = 0`, `in_allowin = 1`, `out_data = 0`.
- **Fill/full (DEPTH=4):** push 0x1000/0x13, 0x1004/0x93, 0x1008/0x113, 0x100C/0x193 with `out_ready = 0` -> `count` goes 1,2,3,4. `in_allowin = 0` after the 4th push. A 5th word held on `in_valid` is not stored. `out_data` stays `{0x1000, 0x13}`.
- **Drain from full:** assert `out_ready` for 4 cycles -> words appear in push order, `count` goes 3,2,1,0, and `in_allowin = 1` from the cycle after the first pop.
- **Streaming and wrap-around:** continuous push and pop of 12 sequential PCs starting at 0x2000, with 1 entry preloaded -> `count` stays constant at 1, PCs come out in order with no gaps, and the pointers wrap three times.
- **Cancel with push and pop together:** `count = 2`, `cancle = 1` with `in_valid = 1` and `out_ready = 1` -> that cycle `out_valid = 0`. Next cycle `count = 0` and the offered word is absent. The next push of 0x3000 is output one cycle later.
- **Parameter sweep:** repeat the fill, drain and cancel scenarios with DEPTH=2, DATA_WD=64 and with DEPTH=16, DATA_WD=96 -> full is reached at exactly DEPTH entries and ordering is preserved.
